// File: rtl/Pipe_Buf_Reg_PKG.sv
// Pipe_Buf_Reg_PKG: shared pipeline-register types.
// Load/store unit state and func3 size/sign helpers.
package Pipe_Buf_Reg_PKG;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Undefined encodings fall through to word.
  function automatic lsu_size_e f3_size(
    input logic [2:0] f3
  );
    if (f3 == F3_B || f3 == F3_BU) return SZ_B;
    if (f3 == F3_H || f3 == F3_HU) return SZ_H;
    if (f3 == F3_W) return SZ_W;
    return SZ_W;
  endfunction

  function automatic logic f3_signed(
    input logic [2:0] f3
  );
    return ~f3[2];
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: byte-lane steering for stores,
// lane select and sign/zero extension for loads.
module lsu_data_align
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        func3,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data,
  output logic              mis
);

  lsu_size_e   sz;
  logic        sgn;
  logic [7:0]  b;
  logic [15:0] h;

  assign sz  = f3_size(func3);
  assign sgn = f3_signed(func3);

  // Low offset bits below natural alignment are dropped here.
  assign b = rdata[{off, 3'b000} +: 8];
  assign h = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    be      = 4'b1111;
    wdata   = wr_data;
    ld_data = rdata;
    mis     = 1'b0;
    unique case (1'b1)
      (sz == SZ_B): begin
        be      = 4'b0001 << off;
        wdata   = {4{wr_data[7:0]}};
        ld_data = {{(DATA_W-8){sgn & b[7]}}, b};
      end
      (sz == SZ_H): begin
        mis     = off[0];
        be      = 4'b0011 << {off[1], 1'b0};
        wdata   = {2{wr_data[15:0]}};
        ld_data = {{(DATA_W-16){sgn & h[15]}}, h};
      end
      default: begin
        mis = |off;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage LSU over a req/gnt/rvalid word SRAM.
// MISALIGN_TRAP_EN: reject misaligned half/word instead of masking.
module load_store_unit
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic                  stall,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  misaligned,
  output logic                  m_req,
  output logic                  m_we,
  output logic [DM_ADDRESS-3:0] m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [3:0]            m_be,
  input  logic                  m_gnt,
  input  logic                  m_rvalid,
  input  logic [DATA_W-1:0]     m_rdata
);

`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  lsu_state_e state_q;
  lsu_state_e state_d;

  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              req;
  logic              is_idle;
  logic              accept;
  logic              trap;
  logic [2:0]        sel_f3;
  logic [1:0]        sel_off;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_ld;
  logic              al_mis;

  assign req     = mem_read | mem_write;
  assign is_idle = (state_q == IDLE);
  assign accept  = is_idle & req;
  assign trap    = TRAP_EN & al_mis;

  // Live inputs shape the request; captured ones shape the load reply.
  assign sel_f3  = is_idle ? func3 : f3_q;
  assign sel_off = is_idle ? addr[1:0] : off_q;

  lsu_data_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .func3   (sel_f3),
    .off     (sel_off),
    .wr_data (wr_data),
    .rdata   (m_rdata),
    .be      (al_be),
    .wdata   (al_wdata),
    .ld_data (al_ld),
    .mis     (al_mis)
  );

  assign stall = reset & (accept
               | (state_q == ISSUE)
               | (state_q == WAIT));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (req) state_d = trap ? DONE : ISSUE;
      ISSUE: if (m_gnt) state_d = m_we ? DONE : WAIT;
      WAIT:  if (m_rvalid) state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      f3_q    <= '0;
      off_q   <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q  <= func3;
        off_q <= addr[1:0];
      end
      if (accept && !trap) begin
        m_req   <= 1'b1;
        m_we    <= mem_write;
        m_addr  <= addr[DM_ADDRESS-1:2];
        m_wdata <= mem_write ? al_wdata : '0;
        m_be    <= al_be;
      end else if (state_q == ISSUE && m_gnt) begin
        m_req   <= 1'b0;
        m_we    <= 1'b0;
        m_addr  <= '0;
        m_wdata <= '0;
        m_be    <= '0;
      end
      if (accept && trap) begin
        rd_data <= '0;
      end else if (state_q == WAIT && m_rvalid) begin
        rd_data <= al_ld;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misaligned <= 1'b0;
    else        misaligned <= accept & trap;
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random accesses against a byte-array
// memory model and a behavioural SRAM with random gnt/rvalid delays.
module tb_load_store_unit;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [2:0]  func3;
  logic        stall;
  logic [31:0] rd_data;
  logic        misaligned;
  logic        m_req;
  logic        m_we;
  logic [6:0]  m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rd;
  logic [7:0]  mb [512];
  logic [31:0] sram [128];

  load_store_unit #(
    .DATA_W     (32),
    .DM_ADDRESS (9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wr_data    (wr_data),
    .func3      (func3),
    .stall      (stall),
    .rd_data    (rd_data),
    .misaligned (misaligned),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_be       (m_be),
    .m_gnt      (m_gnt),
    .m_rvalid   (m_rvalid),
    .m_rdata    (m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one access from its IDLE cycle up to and including DONE.
  // gd = cycles gnt is held low, rd = cycles from gnt to rvalid.
  task automatic access(
    input bit          ld,
    input logic [8:0]  a,
    input logic [2:0]  f3,
    input logic [31:0] wd,
    input int          gd,
    input int          rd
  );
    int sz, aa, nst, nreq, since, exp_stall;
    bit trap, granted, done, req_bad, mis_bad;
    logic [31:0] exp_wd, v, rword, wd0;
    logic [3:0]  exp_be, be0;
    logic [6:0]  a0;
    logic        we0;
    sz = (f3[1:0] == 2'b00) ? 1 :
         (f3[1:0] == 2'b01) ? 2 : 4;
    trap = TRAP && (int'(a) % sz != 0);
    aa = int'(a) - int'(a) % sz;
    exp_be = 4'(((1 << sz) - 1) << (aa % 4));
    for (int i = 0; i < 4; i++)
      exp_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
    if (!trap && !ld)
      for (int j = 0; j < sz; j++) mb[aa+j] = wd[8*j +: 8];
    if (trap) begin
      last_rd = '0;
    end else if (ld) begin
      v = '0;
      for (int j = 0; j < sz; j++) v[8*j +: 8] = mb[aa+j];
      if (!f3[2] && sz < 4 && v[8*sz-1])
        for (int k = 8*sz; k < 32; k++) v[k] = 1'b1;
      last_rd = v;
    end
    exp_stall = trap ? 1 : 2 + gd + (ld ? rd : 0);
    nst = 0; nreq = 0; since = 0;
    granted = 0; done = 0; req_bad = 0; mis_bad = 0;
    a0 = '0; be0 = '0; wd0 = '0; we0 = 1'b0; rword = '0;
    mem_read = ld; mem_write = !ld;
    addr = a; func3 = f3; wr_data = wd;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (c == 0) check("gap_req", {31'd0, m_req}, 32'd0);
      if (stall) begin
        nst++;
        if (misaligned) mis_bad = 1;
        if (m_req) begin
          if (nreq == 0) begin
            a0 = m_addr; be0 = m_be;
            wd0 = m_wdata; we0 = m_we;
          end else if (m_addr !== a0 || m_be !== be0 ||
                       m_wdata !== wd0 || m_we !== we0) begin
            req_bad = 1;
          end
          nreq++;
          if (nreq == gd + 1) begin
            m_gnt = 1'b1;
            granted = 1;
            rword = sram[m_addr];
            if (m_we)
              for (int i = 0; i < 4; i++)
                if (m_be[i]) sram[m_addr][8*i +: 8] = m_wdata[8*i +: 8];
          end else begin
            m_rvalid = 1'($urandom_range(0, 1));
            m_rdata  = $urandom;
          end
        end else if (granted) begin
          since++;
          if (since == rd) begin
            m_rvalid = 1'b1;
            m_rdata  = rword;
          end else begin
            m_gnt   = 1'($urandom_range(0, 1));
            m_rdata = $urandom;
          end
        end
      end else begin
        done = 1;
      end
      if (!done) begin
        @(posedge clk);
        @(negedge clk);
        m_gnt = 1'b0;
        m_rvalid = 1'b0;
      end
    end
    check("done", {31'd0, done}, 32'd1);
    check("stall_cyc", nst, exp_stall);
    check("mis", {31'd0, misaligned}, {31'd0, trap});
    check("rd_data", rd_data, last_rd);
    check("req_done", {31'd0, m_req}, 32'd0);
    check("req_cnt", nreq, trap ? 0 : gd + 1);
    check("mis_early", {31'd0, mis_bad}, 32'd0);
    check("req_hold", {31'd0, req_bad}, 32'd0);
    if (!trap) begin
      check("m_addr", {25'd0, a0}, aa >> 2);
      check("m_be", {28'd0, be0}, {28'd0, exp_be});
      check("m_we", {31'd0, we0}, {31'd0, !ld});
      if (!ld) check("m_wdata", wd0, exp_wd);
    end
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic idle_cycle();
    #1;
    check("idle_stall", {31'd0, stall}, 32'd0);
    check("idle_req", {31'd0, m_req}, 32'd0);
    check("idle_mis", {31'd0, misaligned}, 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] st_f3 [6];
    logic [2:0] ld_f3 [8];
    st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100,
              3'b101, 3'b011, 3'b110, 3'b111};
    reset = 1'b0;
    mem_read = 1'b0; mem_write = 1'b1;
    addr = '0; wr_data = '0; func3 = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    last_rd = '0;
    for (int w = 0; w < 128; w++) begin
      sram[w] = $urandom;
      for (int i = 0; i < 4; i++) mb[4*w+i] = sram[w][8*i +: 8];
    end
    @(negedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, m_req}, 32'd0);
    check("rst_be", {28'd0, m_be}, 32'd0);
    check("rst_addr", {25'd0, m_addr}, 32'd0);
    check("rst_wdata", m_wdata, 32'd0);
    check("rst_rd", rd_data, 32'd0);
    check("rst_mis", {31'd0, misaligned}, 32'd0);
    mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle_cycle();

    access(0, 9'h010, 3'b010, 32'hDEADBEEF, 0, 1);
    access(0, 9'h013, 3'b000, 32'h000000A5, 0, 1);
    access(1, 9'h013, 3'b000, 32'h0, 0, 1);
    access(1, 9'h013, 3'b100, 32'h0, 0, 1);
    access(0, 9'h010, 3'b010, 32'h80011234, 1, 1);
    access(1, 9'h012, 3'b001, 32'h0, 3, 2);
    access(1, 9'h006, 3'b010, 32'h0, 0, 1);
    idle_cycle();
    access(0, 9'h040, 3'b010, 32'h5A5AC3C3, 0, 1);
    access(1, 9'h040, 3'b010, 32'h0, 0, 1);
    access(1, 9'h013, 3'b100, 32'h0, 0, 1);

    // Reset while the request is outstanding, then a stale rvalid.
    mem_read = 1'b1; addr = 9'h020; func3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_mid_req", {31'd0, m_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_drop", {31'd0, m_req}, 32'd0);
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    check("rst_mid_rd", rd_data, 32'd0);
    mem_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_rvalid = 1'b1;
    m_rdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    m_rvalid = 1'b0;
    last_rd = '0;
    #1;
    check("stale_rv_rd", rd_data, 32'd0);
    check("stale_rv_stall", {31'd0, stall}, 32'd0);
    check("stale_rv_req", {31'd0, m_req}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    access(1, 9'h010, 3'b010, 32'h0, 0, 1);

    for (int n = 0; n < 300; n++) begin
      bit          ld;
      logic [2:0]  f3;
      ld = 1'($urandom_range(0, 1));
      f3 = ld ? ld_f3[$urandom_range(0, 7)]
              : st_f3[$urandom_range(0, 5)];
      access(ld, 9'($urandom_range(0, 511)), f3, $urandom,
             $urandom_range(0, 3), $urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
